// File: rtl/split_pkg.sv
// Shared types and constants for the split_sampler candidate generator.
// Provides the FSM state enum, LFSR constants and the word-count helper.
package split_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        CHECK,
        HOLD
    } state_t;

    localparam logic [31:0] LFSR_POLY      = 32'h80200003;
    localparam logic [31:0] LFSR_SEED_DFLT = 32'h00000001;

    // Number of 32-bit words needed to cover a w-bit candidate.
    function automatic int WORDS_F(input int w);
        return (w + 31) / 32;
    endfunction

endpackage

// File: rtl/split_lfsr.sv
// 32-bit Galois LFSR (left-shifting, feedback taps LFSR_POLY).
// Ports: clk, rst_n (async low), load/seed (reseed), step (advance), q (state).
module split_lfsr
    import split_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_SEED_DFLT;
        end else if (load) begin
            // An all-zero state would lock up the LFSR.
            q <= (seed == 32'h0) ? LFSR_SEED_DFLT : seed;
        end else if (step) begin
            q <= {q[30:0], 1'b0} ^ (q[31] ? LFSR_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/split_sampler.sv
// Random candidate generator: fills CAND_W bits from an LFSR, samples the
// checker verdict, offers accepted candidates on a valid/ready handshake.
// Ports: clk, rst_n, start_i, seed_i, cand_o, sat_i, sol_valid_o,
//        sol_ready_i, sol_o, busy_o, fail_o, tries_o
//        (+ rej_total_o when SPLIT_SAMPLER_STATS_EN is defined).
module split_sampler
    import split_pkg::*;
#(
    parameter int CAND_W    = 185,
    parameter int MAX_TRIES = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic [31:0]                    seed_i,
    output logic [CAND_W-1:0]              cand_o,
    input  logic                           sat_i,
    output logic                           sol_valid_o,
    input  logic                           sol_ready_i,
    output logic [CAND_W-1:0]              sol_o,
    output logic                           busy_o,
    output logic                           fail_o,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_o
`ifdef SPLIT_SAMPLER_STATS_EN
    ,
    output logic [31:0]                    rej_total_o
`endif
);

    localparam int WORDS = WORDS_F(CAND_W);
    localparam int TW    = $clog2(MAX_TRIES + 1);
    localparam int CW    = $clog2(WORDS + 1);

    localparam logic [TW-1:0] MAX_T = TW'(MAX_TRIES);
    localparam logic [CW-1:0] WLAST = CW'(WORDS - 1);

    state_t            r_state;
    logic [CAND_W-1:0] r_cand;
    logic [CW-1:0]     r_wcnt;
    logic [TW-1:0]     r_tries;
    logic              r_valid;
    logic              r_busy;
    logic              r_fail;

    logic [31:0]       w_lfsr_q;
    logic              w_load;
    logic              w_step;
    logic [TW-1:0]     w_tries_inc;

    assign w_load = (r_state == IDLE) && start_i;
    assign w_step = (r_state == GEN);

    assign w_tries_inc = (r_tries == MAX_T) ? r_tries : r_tries + 1'b1;

    split_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .seed  (seed_i),
        .step  (w_step),
        .q     (w_lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cand  <= '0;
            r_wcnt  <= '0;
            r_tries <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_tries <= '0;
                        r_fail  <= 1'b0;
                        r_wcnt  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= GEN;
                    end
                end
                GEN: begin
                    // Bits above CAND_W fall off; only the low part is kept.
                    r_cand <= (r_cand << 32) | CAND_W'(w_lfsr_q);
                    r_wcnt <= r_wcnt + 1'b1;
                    if (r_wcnt == WLAST) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    r_tries <= w_tries_inc;
                    if (sat_i) begin
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end else if (w_tries_inc == MAX_T) begin
                        r_fail  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_wcnt  <= '0;
                        r_state <= GEN;
                    end
                end
                HOLD: begin
                    if (sol_ready_i) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cand_o      = r_cand;
    assign sol_o       = r_cand;
    assign sol_valid_o = r_valid;
    assign busy_o      = r_busy;
    assign fail_o      = r_fail;
    assign tries_o     = r_tries;

`ifdef SPLIT_SAMPLER_STATS_EN
    logic [31:0] r_rej_total;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rej_total <= '0;
        end else if ((r_state == CHECK) && !sat_i) begin
            r_rej_total <= r_rej_total + 32'd1;
        end
    end

    assign rej_total_o = r_rej_total;
`else
    // Reject statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_split_sampler.sv
// Directed/randomized bench for split_sampler with a word-level LFSR model.
// Covers reset, accept/reject timing, exhaustion, back-pressure, seed 0.
module tb_split_sampler;

    localparam logic [31:0] POLY = 32'h80200003;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         start;
    logic [31:0]  seed;
    logic         sat;
    logic         ready;
    logic [184:0] cand;
    logic         valid;
    logic [184:0] sol;
    logic         busy;
    logic         fail;
    logic [10:0]  tries;
`ifdef SPLIT_SAMPLER_STATS_EN
    logic [31:0]  rej_total;
    logic [31:0]  rej_total4;
`endif

    logic         start4;
    logic [184:0] cand4;
    logic         valid4;
    logic [184:0] sol4;
    logic         busy4;
    logic         fail4;
    logic [2:0]   tries4;

    int rej_n;
    int checks;
    int errors;

    always #5 clk = ~clk;

    // The checker accepts once rej_n candidates have been rejected.
    assign sat = (int'(tries) >= rej_n);

    split_sampler u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .seed_i      (seed),
        .cand_o      (cand),
        .sat_i       (sat),
        .sol_valid_o (valid),
        .sol_ready_i (ready),
        .sol_o       (sol),
        .busy_o      (busy),
        .fail_o      (fail),
        .tries_o     (tries)
`ifdef SPLIT_SAMPLER_STATS_EN
        ,
        .rej_total_o (rej_total)
`endif
    );

    split_sampler #(.CAND_W(185), .MAX_TRIES(4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start4),
        .seed_i      (seed),
        .cand_o      (cand4),
        .sat_i       (1'b0),
        .sol_valid_o (valid4),
        .sol_ready_i (1'b1),
        .sol_o       (sol4),
        .busy_o      (busy4),
        .fail_o      (fail4),
        .tries_o     (tries4)
`ifdef SPLIT_SAMPLER_STATS_EN
        ,
        .rej_total_o (rej_total4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs,
                       input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_step(input logic [31:0] x);
        return (x << 1) ^ ((x >> 31) != 0 ? POLY : 32'h0);
    endfunction

    // Candidate after rej rejected tries: each try consumes 6 LFSR words,
    // first word ends up most significant, result truncated to 185 bits.
    task automatic model_cand(input logic [31:0] sd, input int rej,
                              output logic [184:0] c);
        logic [31:0]  s;
        logic [191:0] v;
        s = (sd == 32'h0) ? 32'h1 : sd;
        v = '0;
        for (int t = 0; t <= rej; t++) begin
            v = '0;
            for (int w = 0; w < 6; w++) begin
                v = (v << 32) | 192'(s);
                s = m_step(s);
            end
        end
        c = v[184:0];
    endtask

    task automatic start_wait(input logic [31:0] sd, input int rej,
                              output int cyc);
        rej_n = rej;
        seed  = sd;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (!valid && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] sd,
                           input int rej, output logic [184:0] got);
        int           cyc;
        logic [184:0] exp;
        start_wait(sd, rej, cyc);
        model_cand(sd, rej, exp);
        got = sol;
        chk({tag, "_lat"}, 192'(cyc), 192'(7 * (rej + 1)));
        chk({tag, "_tries"}, 192'(tries), 192'(rej + 1));
        chk({tag, "_sol"}, 192'(sol), 192'(exp));
        chk({tag, "_cand"}, 192'(cand), 192'(exp));
        chk({tag, "_busy"}, 192'(busy), 192'(1));
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk({tag, "_vdone"}, 192'(valid), 192'(0));
        chk({tag, "_bdone"}, 192'(busy), 192'(0));
        chk({tag, "_fail"}, 192'(fail), 192'(0));
    endtask

    initial begin
        logic [184:0] got;
        logic [184:0] got0;
        logic [184:0] exp;
        logic [31:0]  sd;
        int           cyc;
        bit           saw_v;

        checks = 0;
        errors = 0;
        rej_n  = 0;
        start  = 1'b0;
        start4 = 1'b0;
        seed   = 32'h0;
        ready  = 1'b0;
        rst_n  = 1'b0;

        #2;
        chk("rst_cand", 192'(cand), 192'(0));
        chk("rst_sol", 192'(sol), 192'(0));
        chk("rst_valid", 192'(valid), 192'(0));
        chk("rst_busy", 192'(busy), 192'(0));
        chk("rst_fail", 192'(fail), 192'(0));
        chk("rst_tries", 192'(tries), 192'(0));
        #18;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_one("first", 32'h0000ACE1, 0, got);
        run_one("rej3", $urandom, 3, got);

        for (int i = 0; i < 4; i++) begin
            run_one("rand", $urandom, int'($urandom_range(0, 3)), got);
        end

        // Exhaustion with MAX_TRIES = 4 and a checker that never accepts.
        start4 = 1'b1;
        seed   = $urandom;
        tick();
        start4 = 1'b0;
        cyc    = 0;
        saw_v  = 1'b0;
        while (busy4 && cyc < 400) begin
            tick();
            cyc++;
            if (valid4) saw_v = 1'b1;
        end
        chk("ex_lat", 192'(cyc), 192'(28));
        chk("ex_fail", 192'(fail4), 192'(1));
        chk("ex_tries", 192'(tries4), 192'(4));
        chk("ex_busy", 192'(busy4), 192'(0));
        chk("ex_novalid", 192'(saw_v), 192'(0));
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("ex_failclr", 192'(fail4), 192'(0));
        chk("ex_trclr", 192'(tries4), 192'(0));
        chk("ex_busy2", 192'(busy4), 192'(1));

        // Back-pressure in HOLD with ignored start pulses.
        sd = $urandom;
        start_wait(sd, 1, cyc);
        model_cand(sd, 1, exp);
        chk("bp_lat", 192'(cyc), 192'(14));
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            seed  = ~sd;
            tick();
            chk("bp_sol", 192'(sol), 192'(exp));
            chk("bp_valid", 192'(valid), 192'(1));
        end
        ready = 1'b1;
        start = 1'b1;
        tick();
        ready = 1'b0;
        start = 1'b0;
        chk("bp_vdone", 192'(valid), 192'(0));
        chk("bp_bdone", 192'(busy), 192'(0));
        tick();
        chk("bp_idle", 192'(busy), 192'(0));

        // Seed 0 behaves as seed 1.
        run_one("seed0", 32'h0, 0, got0);
        run_one("seed1", 32'h1, 0, got);
        chk("seed_eq", 192'(got0), 192'(got));

        // Asynchronous reset in the middle of GEN.
        rej_n = 0;
        seed  = $urandom;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_busy", 192'(busy), 192'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_cand", 192'(cand), 192'(0));
        chk("mr_sol", 192'(sol), 192'(0));
        chk("mr_valid", 192'(valid), 192'(0));
        chk("mr_busy", 192'(busy), 192'(0));
        chk("mr_fail", 192'(fail), 192'(0));
        chk("mr_tries", 192'(tries), 192'(0));
        chk("mr_busy4", 192'(busy4), 192'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_one("post_rst", $urandom, 2, got);

`ifdef SPLIT_SAMPLER_STATS_EN
        chk("st_after2", 192'(rej_total), 192'(2));
        run_one("st5", $urandom, 5, got);
        chk("st_total", 192'(rej_total), 192'(7));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
